// File: rtl/ds_stream_feeder.sv
// Stride-subsampling feeder for the 1x1 downsample accumulator: reads the feature map and weight RAMs,
// emits per output row CHANNEL passes of weight burst, reuse pulse and SIZE pixels, behind a 2-stage pipe.
module ds_stream_feeder #(
  parameter int CHANNEL = 64,
  parameter int BATCH   = 2,
  parameter int WIDTH_D = 27,
  parameter int WIDTH_W = 20,
  parameter int SIZE    = 56,
  parameter int STRIDE  = 2,
  parameter int HS_GAP  = 2,
  parameter int ROW_GAP = 3700,
  parameter int FM_AW   = 20,
  parameter int WT_AW   = 11
) (
  input  logic                       i_sclk,
  input  logic                       i_rst,
  input  logic                       i_start,
  output logic                       o_busy,
  output logic                       o_done,
  output logic                       o_fm_rden,
  output logic [FM_AW-1:0]           o_fm_addr,
  input  logic [WIDTH_D-1:0]         i_fm_data,
  output logic                       o_wt_rden,
  output logic [WT_AW-1:0]           o_wt_addr,
  input  logic [WIDTH_W*BATCH-1:0]   i_wt_data,
  output logic                       o_vsync,
  output logic                       o_hsync,
  output logic                       o_reuse,
  output logic                       o_valid,
  output logic [WIDTH_D-1:0]         o_tdata,
  output logic                       o_weight_vld,
  output logic [WIDTH_W*BATCH-1:0]   o_weight
);

  localparam int IN   = SIZE * STRIDE;
  localparam int NW   = CHANNEL / BATCH;
  localparam int CI_W = (CHANNEL > 1) ? $clog2(CHANNEL) : 1;
  localparam int R_W  = (SIZE > 1) ? $clog2(SIZE) : 1;

  if (CHANNEL % BATCH != 0) begin : gBatchCheck
    $error("ds_stream_feeder: CHANNEL must be a multiple of BATCH");
  end
  if (CHANNEL * IN * IN > (1 << FM_AW)) begin : gFmAwCheck
    $error("ds_stream_feeder: FM_AW too narrow for the feature map");
  end
  if (CHANNEL * NW > (1 << WT_AW)) begin : gWtAwCheck
    $error("ds_stream_feeder: WT_AW too narrow for the weight table");
  end

  typedef enum logic [3:0] {
    IDLE, VS, VG, HS, HG, WT, RU, PX, RG, DN
  } state_t;

  state_t            state_q, state_d;
  logic [31:0]       cnt_q, cnt_d;
  logic [CI_W-1:0]   chan_q, chan_d;
  logic [R_W-1:0]    row_q, row_d;
  logic              busy_q;

  logic reqVs, reqHs, reqRu, reqDn, fmRden, wtRden, rowDone;

  logic vsP1_q, hsP1_q, ruP1_q, dnP1_q, fmVldP1_q, wtVldP1_q;
  logic vsync_q, hsync_q, reuse_q, done_q, valid_q, weightVld_q;
  logic [WIDTH_D-1:0]       tdata_q;
  logic [WIDTH_W*BATCH-1:0] weight_q;

  always_ff @(posedge i_sclk) begin
    if (i_rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      chan_q  <= '0;
      row_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      chan_q  <= chan_d;
      row_q   <= row_d;
      // busy stays up through the pipeline delay and drops exactly as o_done rises
      if (state_q == IDLE && i_start) busy_q <= 1'b1;
      else if (dnP1_q)                busy_q <= 1'b0;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    chan_d  = chan_q;
    row_d   = row_q;
    reqVs   = 1'b0;
    reqHs   = 1'b0;
    reqRu   = 1'b0;
    reqDn   = 1'b0;
    fmRden  = 1'b0;
    wtRden  = 1'b0;
    rowDone = 1'b0;
    unique case (state_q)
      IDLE: if (i_start) state_d = VS;
      VS: begin
        reqVs   = 1'b1;
        state_d = VG;
      end
      VG: state_d = HS;
      HS: begin
        reqHs   = 1'b1;
        cnt_d   = '0;
        state_d = (HS_GAP > 0) ? HG : WT;
      end
      HG: begin
        if (cnt_q == 32'(HS_GAP - 1)) begin
          cnt_d   = '0;
          state_d = WT;
        end else cnt_d = cnt_q + 32'd1;
      end
      WT: begin
        wtRden = 1'b1;
        if (cnt_q == 32'(NW - 1)) begin
          cnt_d   = '0;
          state_d = RU;
        end else cnt_d = cnt_q + 32'd1;
      end
      RU: begin
        reqRu   = 1'b1;
        cnt_d   = '0;
        state_d = PX;
      end
      PX: begin
        fmRden = 1'b1;
        if (cnt_q == 32'(SIZE - 1)) begin
          cnt_d = '0;
          if (chan_q != CI_W'(CHANNEL - 1)) begin
            chan_d  = chan_q + CI_W'(1);
            state_d = WT;
          end else if (ROW_GAP > 0) state_d = RG;
          else                      rowDone = 1'b1;
        end else cnt_d = cnt_q + 32'd1;
      end
      RG: begin
        if (cnt_q == 32'(ROW_GAP - 1)) rowDone = 1'b1;
        else                           cnt_d = cnt_q + 32'd1;
      end
      DN: begin
        reqDn   = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (rowDone) begin
      cnt_d  = '0;
      chan_d = '0;
      if (row_q != R_W'(SIZE - 1)) begin
        row_d   = row_q + R_W'(1);
        state_d = HS;
      end else begin
        row_d   = '0;
        state_d = DN;
      end
    end
  end

  assign o_fm_rden = fmRden;
  assign o_wt_rden = wtRden;
  assign o_fm_addr = fmRden ? (FM_AW'(chan_q) * FM_AW'(IN * IN)
                              + FM_AW'(row_q) * FM_AW'(STRIDE * IN)
                              + FM_AW'(cnt_q) * FM_AW'(STRIDE)) : '0;
  assign o_wt_addr = wtRden ? (WT_AW'(chan_q) * WT_AW'(NW) + WT_AW'(cnt_q)) : '0;

  // Stage 1 delays sidebands to line up with RAM read data; stage 2 registers and zero-gates the outputs
  always_ff @(posedge i_sclk) begin
    if (i_rst) begin
      vsP1_q      <= 1'b0;
      hsP1_q      <= 1'b0;
      ruP1_q      <= 1'b0;
      dnP1_q      <= 1'b0;
      fmVldP1_q   <= 1'b0;
      wtVldP1_q   <= 1'b0;
      vsync_q     <= 1'b0;
      hsync_q     <= 1'b0;
      reuse_q     <= 1'b0;
      done_q      <= 1'b0;
      valid_q     <= 1'b0;
      weightVld_q <= 1'b0;
      tdata_q     <= '0;
      weight_q    <= '0;
    end else begin
      vsP1_q      <= reqVs;
      hsP1_q      <= reqHs;
      ruP1_q      <= reqRu;
      dnP1_q      <= reqDn;
      fmVldP1_q   <= fmRden;
      wtVldP1_q   <= wtRden;
      vsync_q     <= vsP1_q;
      hsync_q     <= hsP1_q;
      reuse_q     <= ruP1_q;
      done_q      <= dnP1_q;
      valid_q     <= fmVldP1_q;
      weightVld_q <= wtVldP1_q;
      tdata_q     <= fmVldP1_q ? i_fm_data : '0;
      weight_q    <= wtVldP1_q ? i_wt_data : '0;
    end
  end

  assign o_busy       = busy_q;
  assign o_done       = done_q;
  assign o_vsync      = vsync_q;
  assign o_hsync      = hsync_q;
  assign o_reuse      = reuse_q;
  assign o_valid      = valid_q;
  assign o_tdata      = tdata_q;
  assign o_weight_vld = weightVld_q;
  assign o_weight     = weight_q;

endmodule

// File: tb/tb_ds_stream_feeder.sv
// Randomized frame/start/reset stimulus for ds_stream_feeder, checked cycle by cycle against an
// expected output timeline built from the frame schedule (row length, pass layout, address formula).
module tb_ds_stream_feeder;

  localparam int CHANNEL = 4;
  localparam int BATCH   = 2;
  localparam int WIDTH_D = 27;
  localparam int WIDTH_W = 20;
  localparam int SIZE    = 4;
  localparam int STRIDE  = 2;
  localparam int HS_GAP  = 1;
  localparam int ROW_GAP = 8;
  localparam int FM_AW   = 20;
  localparam int WT_AW   = 11;

  localparam int IN      = SIZE * STRIDE;
  localparam int NW      = CHANNEL / BATCH;
  localparam int ROW_LEN = 1 + HS_GAP + CHANNEL * (NW + 1 + SIZE) + ROW_GAP;
  localparam int FRAME   = 5 + SIZE * ROW_LEN;
  localparam int MAXC    = 4000;
  localparam int WB      = WIDTH_W * BATCH;

  logic clk = 1'b0;
  logic i_rst, i_start;
  logic busy, done, fmRden, wtRden;
  logic vsync, hsync, reuse, valid, weightVld;
  logic [FM_AW-1:0]   fmAddr;
  logic [WT_AW-1:0]   wtAddr;
  logic [WIDTH_D-1:0] fmData = '0;
  logic [WB-1:0]      wtData = '0;
  logic [WIDTH_D-1:0] tdata;
  logic [WB-1:0]      weight;

  int total = 0;
  int bad   = 0;
  int endCyc;

  logic stimStart [MAXC];
  logic stimRst   [MAXC];
  logic expVs [MAXC], expHs [MAXC], expRu [MAXC], expV [MAXC];
  logic expWv [MAXC], expDone [MAXC], expBusy [MAXC];
  logic [WIDTH_D-1:0] expD [MAXC];
  logic [WB-1:0]      expW [MAXC];

  always #5 clk = ~clk;

  ds_stream_feeder #(
    .CHANNEL(CHANNEL), .BATCH(BATCH), .WIDTH_D(WIDTH_D), .WIDTH_W(WIDTH_W),
    .SIZE(SIZE), .STRIDE(STRIDE), .HS_GAP(HS_GAP), .ROW_GAP(ROW_GAP),
    .FM_AW(FM_AW), .WT_AW(WT_AW)
  ) dut (
    .i_sclk(clk), .i_rst(i_rst), .i_start(i_start),
    .o_busy(busy), .o_done(done),
    .o_fm_rden(fmRden), .o_fm_addr(fmAddr), .i_fm_data(fmData),
    .o_wt_rden(wtRden), .o_wt_addr(wtAddr), .i_wt_data(wtData),
    .o_vsync(vsync), .o_hsync(hsync), .o_reuse(reuse),
    .o_valid(valid), .o_tdata(tdata),
    .o_weight_vld(weightVld), .o_weight(weight)
  );

  // Every weight slot of beat a holds the value a
  function automatic logic [WB-1:0] beatOf(int a);
    logic [WB-1:0] v;
    for (int j = 0; j < BATCH; j++) v[j*WIDTH_W +: WIDTH_W] = WIDTH_W'(a);
    return v;
  endfunction

  // 1-cycle-latency RAMs: fm[a] = a, wt[a] = a per slot; garbage when not read
  always @(posedge clk) begin
    if (fmRden) fmData <= WIDTH_D'(fmAddr);
    else        fmData <= WIDTH_D'($urandom);
    if (wtRden) wtData <= beatOf(int'(wtAddr));
    else        wtData <= WB'({$urandom, $urandom});
  end

  task automatic clearFrom(int c);
    for (int t = c; t < MAXC; t++) begin
      expVs[t] = 0; expHs[t] = 0; expRu[t] = 0; expV[t] = 0;
      expWv[t] = 0; expDone[t] = 0; expBusy[t] = 0;
      expD[t] = '0; expW[t] = '0;
    end
  endtask

  // Output timeline of a frame whose start is accepted in cycle a
  task automatic scheduleFrame(int a);
    int h, p, t;
    for (t = a + 1; t < a + FRAME; t++) expBusy[t] = 1;
    expVs[a + 3] = 1;
    for (int r = 0; r < SIZE; r++) begin
      h = a + 3 + r * ROW_LEN;
      expHs[h + 2] = 1;
      for (int ci = 0; ci < CHANNEL; ci++) begin
        p = h + 1 + HS_GAP + ci * (NW + 1 + SIZE);
        for (int k = 0; k < NW; k++) begin
          expWv[p + 2 + k] = 1;
          expW[p + 2 + k]  = beatOf(ci * NW + k);
        end
        expRu[p + NW + 2] = 1;
        for (int x = 0; x < SIZE; x++) begin
          t = p + NW + 3 + x;
          expV[t] = 1;
          expD[t] = WIDTH_D'(ci * IN * IN + STRIDE * r * IN + STRIDE * x);
        end
      end
    end
    expDone[a + FRAME] = 1;
  endtask

  task automatic planStimulus();
    int t, rc, mode;
    for (int c = 0; c < MAXC; c++) begin
      stimStart[c] = 0;
      stimRst[c]   = (c < 4);
    end
    t = 6;
    stimStart[t] = 1;
    stimStart[t + 20] = 1;
    t = t + FRAME + 4;
    stimStart[t] = 1;
    stimRst[t + 11] = 1;
    stimStart[t + 20] = 1;
    t = t + 20 + FRAME + 4;
    for (int f = 0; f < 5; f++) begin
      stimStart[t] = 1;
      mode = int'($urandom_range(0, 2));
      if (mode == 2) begin
        rc = t + int'($urandom_range(1, 150));
        stimRst[rc] = 1;
        t = rc + int'($urandom_range(1, 10));
      end else begin
        if (mode == 1) stimStart[t + int'($urandom_range(1, 150))] = 1;
        t = t + FRAME + int'($urandom_range(2, 10));
      end
    end
    endCyc = t + FRAME + 10;
  endtask

  task automatic buildModel();
    int idleFrom = 0;
    clearFrom(0);
    for (int c = 0; c < endCyc; c++) begin
      if (stimRst[c]) begin
        clearFrom(c + 1);
        idleFrom = c + 1;
      end else if (stimStart[c] && c >= idleFrom) begin
        scheduleFrame(c);
        idleFrom = c + FRAME - 1;
      end
    end
  endtask

  task automatic checkOutput(string tag, logic [63:0] got, logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  task automatic applyStimulus(int c);
    i_rst   = stimRst[c];
    i_start = stimStart[c];
  endtask

  task automatic checkCycle(int c);
    checkOutput($sformatf("vsync@%0d", c), 64'(vsync), 64'(expVs[c]));
    checkOutput($sformatf("hsync@%0d", c), 64'(hsync), 64'(expHs[c]));
    checkOutput($sformatf("reuse@%0d", c), 64'(reuse), 64'(expRu[c]));
    checkOutput($sformatf("valid@%0d", c), 64'(valid), 64'(expV[c]));
    checkOutput($sformatf("tdata@%0d", c), 64'(tdata), 64'(expD[c]));
    checkOutput($sformatf("wvld@%0d", c), 64'(weightVld), 64'(expWv[c]));
    checkOutput($sformatf("weight@%0d", c), 64'(weight), 64'(expW[c]));
    checkOutput($sformatf("done@%0d", c), 64'(done), 64'(expDone[c]));
    checkOutput($sformatf("busy@%0d", c), 64'(busy), 64'(expBusy[c]));
  endtask

  initial begin
    i_rst   = 1'b1;
    i_start = 1'b0;
    planStimulus();
    buildModel();
    $display("[TB] running %0d cycles", endCyc);
    for (int c = 0; c < endCyc; c++) begin
      applyStimulus(c);
      @(posedge clk);
      @(negedge clk);
      checkCycle(c + 1);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ds_stream_feeder.md
Name: ds_stream_feeder

Overview:
- Transmitter side of the pixel/weight stream consumed by the stride-2 1x1 downsample accumulator (vsync/hsync/reuse/valid/tdata plus weight_vld/weight).
- Reads an input feature map (channel-major) and a weight table from external 1-cycle-latency SDP RAM read ports.
- Applies stride subsampling and emits, per output row, CHANNEL passes. Each pass is a weight-load burst, then a reuse pulse, then SIZE pixels of one input channel.
- Paces rows with a programmable drain gap so the downstream accumulator can flush.

Parameters:
- CHANNEL, 64, input channels = output channels
- BATCH, 2, weights per weight beat; CHANNEL % BATCH == 0 (elaboration error otherwise); NW = CHANNEL/BATCH
- WIDTH_D, 27, pixel width
- WIDTH_W, 20, single weight width
- SIZE, 56, output row length and output row count
- STRIDE, 2, subsampling step; input side IN = SIZE*STRIDE
- HS_GAP, 2, idle request cycles after hsync before first weight beat
- ROW_GAP, 3700, idle request cycles after last pixel of a row (downstream drain); minimum 0
- FM_AW, 20, feature RAM address width (>= clog2(CHANNEL*IN*IN))
- WT_AW, 11, weight RAM address width (>= clog2(CHANNEL*NW))

Ports:
- i_sclk  in  1  clock
- i_rst  in  1  synchronous active-high reset
- i_start  in  1  frame start pulse; ignored unless idle
- o_busy  out  1  high from start acceptance until o_done
- o_done  out  1  one-cycle frame-complete pulse
- o_fm_rden  out  1  feature RAM read enable
- o_fm_addr  out  FM_AW  feature address = ci*IN*IN + (STRIDE*r)*IN + STRIDE*x
- i_fm_data  in  WIDTH_D  feature data, valid 1 cycle after o_fm_rden
- o_wt_rden  out  1  weight RAM read enable
- o_wt_addr  out  WT_AW  weight address = ci*NW + k
- i_wt_data  in  WIDTH_W*BATCH  weight beat, valid 1 cycle after o_wt_rden
- o_vsync  out  1  frame-start pulse (downstream clear)
- o_hsync  out  1  row-start pulse
- o_reuse  out  1  weight-latch pulse, one per channel pass
- o_valid  out  1  pixel strobe
- o_tdata  out  WIDTH_D  pixel, 0 when o_valid low
- o_weight_vld  out  1  weight beat strobe
- o_weight  out  WIDTH_W*BATCH  weight beat, 0 when o_weight_vld low

Behaviour:
- Clocking/reset: one clock i_sclk; reset i_rst is synchronous, active-high.
- Reset state: all outputs 0, FSM IDLE, counters 0, 2-stage output pipeline flushed.
- Mid-frame reset: the next cycle has all outputs 0. No o_done is issued.
- FSM (request side): IDLE -> VS (1 cyc) -> VG (1 cyc) -> HS (1 cyc) -> HG (HS_GAP cyc, skipped if 0) -> WT (NW cyc) -> RU (1 cyc) -> PX (SIZE cyc).
- After PX:
  - If ci < CHANNEL-1: ci++, go to WT.
  - Else go to RG (ROW_GAP cyc). Then, if r < SIZE-1: r++, ci=0, go to HS; else go to DN (1 cyc) -> IDLE.
- Request per state: WT issues o_wt_rden with k = 0..NW-1. PX issues o_fm_rden with x = 0..SIZE-1. VS/HS/RU/DN raise vsync/hsync/reuse/done requests.
- Output pipeline: every request-side event at cycle t appears on outputs at t+2. Stage 1 is the RAM read plus sideband delay; stage 2 is the output register. Data and strobes are always mutually aligned.
- Output timing guarantees:
  - Consecutive o_valid bursts are separated by exactly NW+1 cycles.
  - o_reuse is the cycle immediately before the first o_valid of each pass.
  - The last o_weight_vld is the cycle immediately before o_reuse.
- Weight beat order: k=0 first. The downstream shifts beats in at the MSB, so after NW beats beat k occupies weights [k*BATCH .. k*BATCH+BATCH-1].
- o_busy: set the cycle after i_start is sampled in IDLE; cleared the same cycle o_done rises.
- Row length (request cycles) = 1 + HS_GAP + CHANNEL*(NW+1+SIZE) + ROW_GAP.
- Address arithmetic is unsigned with no wrap inside a frame; FM_AW/WT_AW too narrow is a config error.

Test Plan:
- Small config: CHANNEL=4, BATCH=2, SIZE=4, STRIDE=2, HS_GAP=1, ROW_GAP=8; i_start at cycle 0.
  - Expected: o_vsync at 3, o_hsync at 5, o_weight_vld at 7-8, o_reuse at 9, o_valid at 10-13.
  - o_tdata there = fm[0], fm[2], fm[4], fm[6].
- Same config, second pass: o_weight_vld at 14-15 carrying wt[2], wt[3]; o_reuse at 16; o_valid at 17-20 with fm[64], fm[66], fm[68], fm[70].
- Row pacing: row length 38, so the second o_hsync is at 43 with first pixel fm[16]; final o_done pulse at 157; o_busy high 1..156.
- i_start pulsed at cycle 20 mid-frame -> ignored; sequence identical to the first scenario.
- i_rst asserted at cycle 11 -> all outputs 0 from cycle 12; no o_done; a new i_start at 20 gives o_vsync at 23.
- Data integrity: fm[a]=a and wt[a] = a replicated per weight (each beat's weight slots all equal a) -> every o_tdata equals the address formula; o_tdata and o_weight are 0 whenever their strobes are low.
